// File: rtl/firebird7_in_gate1_secure_sib_pkg.sv
// Shared constants, helpers and the lockout state type for the firebird7_in gate1 secure SIB.
// Field layout: select bit at index KEY_W, key field at [KEY_W-1:0].
package firebird7_in_gate1_secure_sib_pkg;

  localparam int KEY_W_DEFAULT = 16;
  localparam int SEL_IDX       = KEY_W_DEFAULT;
  localparam int KEY_MSB       = KEY_W_DEFAULT - 1;
  localparam int KEY_LSB       = 0;

  typedef enum logic {
    LOCK_UNLOCKED = 1'b0,
    LOCK_LOCKED   = 1'b1
  } lock_state_e;

  function automatic int fc_w(input int max_fail);
    return $clog2(max_fail + 1);
  endfunction

  function automatic int sel_idx(input int key_w);
    return key_w;
  endfunction

  function automatic int key_msb(input int key_w);
    return key_w - 1;
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_secure_sib_lockout.sv
// Key comparator, consecutive wrong-key counter and sticky lock flag.
// Only instantiated when FIREBIRD7_SECURE_SIB_LOCKOUT_EN is defined.
module firebird7_in_gate1_secure_sib_lockout
  import firebird7_in_gate1_secure_sib_pkg::*;
#(
  parameter int               KEY_W     = KEY_W_DEFAULT,
  parameter logic [KEY_W-1:0] KEY_VALUE = 16'hA5C3,
  parameter int               MAX_FAIL  = 3,
  parameter int               FC_W      = fc_w(MAX_FAIL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd_en,
  input  logic [KEY_W-1:0] key_field,
  output logic             sel_load,
  output logic             lock_set,
  output logic [FC_W-1:0]  fail_cnt,
  output logic             locked
);

  localparam int              FC_X       = FC_W + 1;
  localparam logic [FC_W:0]   FAIL_LIMIT = FC_X'(MAX_FAIL);

  lock_state_e      state_q, state_d;
  logic [FC_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic             key_ok;
  logic             at_limit;

  always_comb begin
    key_ok     = (key_field == KEY_VALUE);
    at_limit   = (({1'b0, fail_cnt_q} + 1'b1) == FAIL_LIMIT);
    sel_load   = 1'b0;
    lock_set   = 1'b0;
    state_d    = state_q;
    fail_cnt_d = fail_cnt_q;
    // A locked register ignores every update until reset.
    if (upd_en && (state_q == LOCK_UNLOCKED)) begin
      if (key_ok) begin
        sel_load   = 1'b1;
        fail_cnt_d = '0;
      end else if (at_limit) begin
        lock_set   = 1'b1;
        state_d    = LOCK_LOCKED;
        fail_cnt_d = FAIL_LIMIT[FC_W-1:0];
      end else begin
        fail_cnt_d = fail_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOCK_UNLOCKED;
      fail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign fail_cnt = fail_cnt_q;
  assign locked   = (state_q == LOCK_LOCKED);

endmodule

// File: rtl/firebird7_in_gate1_tessent_secure_sib_ctrl.sv
// Key-protected IJTAG segment-select register driving the gate1 secure scan mux.
// Fail counter / lockout is built only when FIREBIRD7_SECURE_SIB_LOCKOUT_EN is defined.
module firebird7_in_gate1_tessent_secure_sib_ctrl
  import firebird7_in_gate1_secure_sib_pkg::*;
#(
  parameter int               KEY_W     = KEY_W_DEFAULT,
  parameter logic [KEY_W-1:0] KEY_VALUE = 16'hA5C3,
  parameter int               MAX_FAIL  = 3
) (
  input  logic ijtag_tck,
  input  logic ijtag_reset,
  input  logic ijtag_sel,
  input  logic ijtag_ce,
  input  logic ijtag_se,
  input  logic ijtag_ue,
  input  logic ijtag_si,
  output logic ijtag_so,
  output logic mux_select,
  output logic enable_out,
  output logic locked
);

  localparam int SEL_POS = sel_idx(KEY_W);
  localparam int KEY_HI  = key_msb(KEY_W);
  localparam int FC_W    = fc_w(MAX_FAIL);

  logic [KEY_W:0]   sr_q, sr_d;
  logic             mux_select_q, mux_select_d;
  logic             cap_en, shf_en, upd_en;
  logic             sel_load, lock_set;
  logic [FC_W:0]    status_bits;
  logic [KEY_W-1:0] status_field;

  assign cap_en = ijtag_sel & ijtag_ce;
  assign shf_en = ijtag_sel & ijtag_se & ~ijtag_ce;
  assign upd_en = ijtag_sel & ijtag_ue;

`ifdef FIREBIRD7_SECURE_SIB_LOCKOUT_EN
  logic [FC_W-1:0] fail_cnt;
  logic            locked_int;

  firebird7_in_gate1_secure_sib_lockout #(
    .KEY_W     (KEY_W),
    .KEY_VALUE (KEY_VALUE),
    .MAX_FAIL  (MAX_FAIL),
    .FC_W      (FC_W)
  ) u_lockout (
    .clk       (ijtag_tck),
    .rst       (ijtag_reset),
    .upd_en    (upd_en),
    .key_field (sr_q[KEY_HI:KEY_LSB]),
    .sel_load  (sel_load),
    .lock_set  (lock_set),
    .fail_cnt  (fail_cnt),
    .locked    (locked_int)
  );

  assign status_bits = {fail_cnt, locked_int};
  assign locked      = locked_int;
`else
  // Without lockout a wrong key is simply ignored and nothing is reported.
  assign sel_load    = upd_en && (sr_q[KEY_HI:KEY_LSB] == KEY_VALUE);
  assign lock_set    = 1'b0;
  assign status_bits = '0;
  assign locked      = 1'b0;
`endif

  assign status_field = KEY_W'(status_bits);

  always_comb begin
    sr_d = sr_q;
    // Capture samples pre-update state, so it uses the _q values.
    if (cap_en) begin
      sr_d = {mux_select_q, status_field};
    end else if (shf_en) begin
      sr_d = {ijtag_si, sr_q[KEY_W:1]};
    end

    mux_select_d = mux_select_q;
    if (sel_load) begin
      mux_select_d = sr_q[SEL_POS];
    end else if (lock_set) begin
      mux_select_d = 1'b0;
    end
  end

  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      sr_q         <= '0;
      mux_select_q <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      mux_select_q <= mux_select_d;
    end
  end

  assign ijtag_so   = sr_q[0];
  assign mux_select = mux_select_q;
  assign enable_out = ijtag_sel;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_secure_sib_ctrl.sv
// Directed bench for the gate1 secure SIB: behavioural model checked every cycle plus literal pins.
// Expectations adapt to whether FIREBIRD7_SECURE_SIB_LOCKOUT_EN is defined.
module tb_firebird7_in_gate1_tessent_secure_sib_ctrl;

  localparam logic [15:0] KEY  = 16'hA5C3;
  localparam int          MAXF = 3;
`ifdef FIREBIRD7_SECURE_SIB_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, sel, ce, se, ue, si;
  logic so, msel, en, lck;

  always #5 clk = ~clk;

  firebird7_in_gate1_tessent_secure_sib_ctrl #(
    .KEY_W     (16),
    .KEY_VALUE (KEY),
    .MAX_FAIL  (MAXF)
  ) dut (
    .ijtag_tck   (clk),
    .ijtag_reset (rst),
    .ijtag_sel   (sel),
    .ijtag_ce    (ce),
    .ijtag_se    (se),
    .ijtag_ue    (ue),
    .ijtag_si    (si),
    .ijtag_so    (so),
    .mux_select  (msel),
    .enable_out  (en),
    .locked      (lck)
  );

  int checks   = 0;
  int failures = 0;

  // Model state: the register contents, the select, a wrong-key tally and lock flag.
  logic [16:0] m_sr     = '0;
  bit          m_msel   = 1'b0;
  bit          m_locked = 1'b0;
  int          m_fails  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  // One clock: advance the model from the applied inputs, then compare after the edge.
  task automatic step();
    logic [16:0] n_sr;
    bit          n_msel, n_locked;
    int          n_fails;
    n_sr = m_sr; n_msel = m_msel; n_locked = m_locked; n_fails = m_fails;
    if (rst) begin
      n_sr = '0; n_msel = 1'b0; n_locked = 1'b0; n_fails = 0;
    end else begin
      if (sel && ce)
        n_sr = {m_msel, 16'(LOCK_EN ? (m_fails * 2 + int'(m_locked)) : 0)};
      else if (sel && se)
        n_sr = {si, m_sr[16:1]};
      if (sel && ue && !m_locked) begin
        if (m_sr[15:0] == KEY) begin
          n_msel  = m_sr[16];
          n_fails = 0;
        end else if (LOCK_EN) begin
          n_fails = m_fails + 1;
          if (n_fails == MAXF) begin
            n_locked = 1'b1;
            n_msel   = 1'b0;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    m_sr = n_sr; m_msel = n_msel; m_locked = n_locked; m_fails = n_fails;
    chk("so", {31'b0, so}, {31'b0, m_sr[0]});
    chk("mux_select", {31'b0, msel}, {31'b0, m_msel});
    chk("enable_out", {31'b0, en}, {31'b0, sel});
    chk("locked", {31'b0, lck}, {31'b0, m_locked});
  endtask

  task automatic idle_all();
    ce = 0; se = 0; ue = 0; si = 0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1; step(); step();
    rst = 0;
  endtask

  task automatic shift_word(input logic [16:0] w);
    sel = 1; ce = 0; ue = 0; se = 1;
    for (int i = 0; i < 17; i++) begin
      si = w[i];
      step();
    end
    idle_all();
  endtask

  task automatic shift_out(output logic [16:0] got);
    sel = 1; ce = 0; ue = 0; se = 1; si = 0;
    for (int i = 0; i < 17; i++) begin
      got[i] = so;
      step();
    end
    idle_all();
  endtask

  task automatic capture_out(output logic [16:0] got);
    sel = 1; idle_all(); ce = 1;
    step();
    ce = 0;
    shift_out(got);
  endtask

  task automatic update();
    sel = 1; idle_all(); ue = 1;
    step();
    ue = 0;
  endtask

  logic [16:0] got;

  initial begin
    rst = 1; sel = 0; idle_all();
    do_reset();
    chk("reset_so", {31'b0, so}, 32'd0);
    chk("reset_msel", {31'b0, msel}, 32'd0);
    chk("reset_locked", {31'b0, lck}, 32'd0);

    capture_out(got);
    chk("reset_capture", {15'b0, got}, 32'h00000);

    // Correct key loads select=1.
    shift_word({1'b1, KEY});
    update();
    chk("goodkey_msel", {31'b0, msel}, 32'd1);
    capture_out(got);
    chk("goodkey_capture", {15'b0, got}, 32'h10000);

    // Single wrong key from reset.
    do_reset();
    shift_word({1'b1, 16'h0000});
    update();
    chk("badkey_msel", {31'b0, msel}, 32'd0);
    capture_out(got);
    chk("badkey_capture", {15'b0, got}, LOCK_EN ? 32'h00002 : 32'h00000);

    // Three wrong keys after select was set.
    do_reset();
    shift_word({1'b1, KEY});
    update();
    shift_word({1'b1, 16'h1234});
    update(); update(); update();
    chk("lock_locked", {31'b0, lck}, LOCK_EN ? 32'd1 : 32'd0);
    chk("lock_msel", {31'b0, msel}, LOCK_EN ? 32'd0 : 32'd1);
    shift_word({1'b1, KEY});
    update();
    chk("locked_goodkey_msel", {31'b0, msel}, LOCK_EN ? 32'd0 : 32'd1);
    capture_out(got);
    chk("locked_capture", {15'b0, got}, LOCK_EN ? 32'h00007 : 32'h10000);
    do_reset();
    chk("unlock_by_reset", {31'b0, lck}, 32'd0);

    // Correct key in between clears the tally.
    shift_word({1'b0, 16'h0000}); update();
    shift_word({1'b0, KEY});      update();
    shift_word({1'b0, 16'hFFFF}); update(); update();
    chk("no_lock_after_clear", {31'b0, lck}, 32'd0);
    capture_out(got);
    chk("tally_capture", {15'b0, got}, LOCK_EN ? 32'h00004 : 32'h00000);

    // Capture and update together: capture sees the old select.
    do_reset();
    shift_word({1'b1, KEY});
    sel = 1; ce = 1; ue = 1;
    step();
    idle_all();
    chk("capupd_msel", {31'b0, msel}, 32'd1);
    shift_out(got);
    chk("capupd_capture", {15'b0, got}, 32'h00000);

    // Deselected register ignores all enables.
    shift_word({1'b1, KEY});
    update();
    sel = 0;
    for (int i = 0; i < 20; i++) begin
      ce = 1'($urandom_range(0, 1));
      se = 1'($urandom_range(0, 1));
      ue = 1'($urandom_range(0, 1));
      si = 1'($urandom_range(0, 1));
      step();
    end
    idle_all();
    chk("sel0_msel", {31'b0, msel}, 32'd1);
    chk("sel0_enable", {31'b0, en}, 32'd0);
    shift_out(got);
    chk("sel0_sr", {15'b0, got}, {15'b0, 1'b1, KEY});

    // Reset in the middle of a shift.
    shift_word(17'h1FFFF);
    sel = 1; se = 1; si = 1;
    for (int i = 0; i < 5; i++) step();
    rst = 1; step();
    rst = 0; idle_all();
    chk("midshift_reset_so", {31'b0, so}, 32'd0);
    chk("midshift_reset_msel", {31'b0, msel}, 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/firebird7_in_gate1_tessent_secure_sib_ctrl.md
# firebird7_in_gate1_tessent_secure_sib_ctrl

Key-protected IJTAG segment-select register for the firebird7_in gate1 network. It holds the select bit that drives the `mux_select` input of the downstream secure scan mux. The select bit changes only when an update carries the correct key, so a protected instrument segment stays bypassed unless the key is presented. Repeated wrong keys lock the register in the deselected state until reset.

## Interface
- `KEY_W`, 16: width of the key field; must be at least `FC_W`+1.
- `KEY_VALUE`, 16'hA5C3: key that must be present in the key field at update.
- `MAX_FAIL`, 3: number of consecutive wrong-key updates that triggers lockout; range 1..15.
- `ijtag_tck`  in  1  sole clock; all state changes on the rising edge.
- `ijtag_reset`  in  1  reset; synchronous, active-high.
- `ijtag_sel`  in  1  register is on the active scan path; gates capture, shift and update.
- `ijtag_ce`  in  1  capture enable.
- `ijtag_se`  in  1  shift enable.
- `ijtag_ue`  in  1  update enable.
- `ijtag_si`  in  1  scan in.
- `ijtag_so`  out  1  scan out; equals `sr[0]`, combinational from the register.
- `mux_select`  out  1  registered select for the downstream secure mux.
- `enable_out`  out  1  equals `ijtag_sel`, combinational; drives the downstream mux `enable_in`.
- `locked`  out  1  lockout active.

## Operation
- Shift register `sr`, width `KEY_W`+1.
  - `sr[KEY_W]` is the select field.
  - `sr[KEY_W-1:0]` is the key field.
- `FC_W` = clog2(`MAX_FAIL`+1). `fail_cnt` is `FC_W` bits wide.
- Capture (`ijtag_sel & ijtag_ce`):
  - `sr` <= {`mux_select`, zero-extended {`fail_cnt`, `locked`}}.
  - Capture wins over shift if both enables are high.
- Shift (`ijtag_sel & ijtag_se & ~ijtag_ce`): `sr` <= {`ijtag_si`, `sr[KEY_W:1]`}. LSB shifts out first.
- Update (`ijtag_sel & ijtag_ue`) is evaluated against the current `sr`:
  - If `locked`: no state change.
  - Else if `sr[KEY_W-1:0]` == `KEY_VALUE`: `mux_select` <= `sr[KEY_W]` and `fail_cnt` <= 0.
  - Else, if `fail_cnt`+1 == `MAX_FAIL`: `locked` <= 1, `mux_select` <= 0, and `fail_cnt` saturates at `MAX_FAIL`.
  - Else: `fail_cnt` <= `fail_cnt`+1 and `mux_select` is unchanged.
- Update does not modify `sr`.
- Capture and update asserted in the same cycle:
  - Both take effect.
  - The capture samples the pre-update values.
- Any enable with `ijtag_sel` low has no effect.
- Lockout states:
  - UNLOCKED (`locked`=0).
  - LOCKED (`locked`=1).
  - The only exit from LOCKED is `ijtag_reset`.

## Timing
- Reset values: `sr`=0, `mux_select`=0, `fail_cnt`=0, `locked`=0. Hence `ijtag_so`=0. `enable_out` follows `ijtag_sel`.
- Reset mid-shift or mid-update discards all partial state. No update is performed in the reset cycle.
- Update latency: `mux_select` and `locked` change at the first rising edge where `ijtag_sel & ijtag_ue` is sampled high.
- `ijtag_so` changes one edge after each shift or capture.
- No handshake; the enables are single-cycle level qualifiers driven by the IJTAG controller.

## Configuration
- `FIREBIRD7_SECURE_SIB_LOCKOUT_EN` defined:
  - Fail counter and lockout are implemented as described above.
- Not defined:
  - `fail_cnt` and `locked` do not exist, and the `locked` output is tied 0.
  - A wrong-key update is ignored: `mux_select` is unchanged and there is no side effect.
  - The captured key field is all zeros.

## Structure
- Package `firebird7_in_gate1_secure_sib_pkg` holds:
  - The field index constants (`SEL_IDX` = `KEY_W`, key field range).
  - The `FC_W` function.
  - The lockout state typedef.
- One sub-module, `firebird7_in_gate1_secure_sib_lockout`:
  - Contains the key comparator, the fail counter and the lock flag.
  - Is instantiated only under the macro.

## Test plan
- Reset, then capture with `ijtag_sel`=1 and shift out 17 bits -> all 17 `ijtag_so` bits are 0; `mux_select`=0; `locked`=0.
- Shift in select=1 with key 16'hA5C3, then update -> `mux_select`=1 on the update edge. A following capture/shift-out shows the MSB = 1.
- Shift in select=1 with key 16'h0000, then update -> `mux_select` stays 0. A captured key field = 16'h0002 (`fail_cnt`=1, `locked`=0).
- Three consecutive wrong-key updates with `mux_select`=1 previously set -> on the 3rd update `locked`=1 and `mux_select`=0.
  - A later update with the correct key has no effect.
  - `ijtag_reset` clears `locked`.
- Wrong key, then correct key -> `fail_cnt` returns to 0. Two further wrong keys do not lock (`MAX_FAIL`=3).
- `ijtag_sel`=0 with `ce`/`se`/`ue` toggling for 20 cycles -> `sr`, `mux_select` and `ijtag_so` unchanged; `enable_out`=0.
  - Build without the macro: repeated wrong keys never assert `locked`.
